instr_encoder_loader: RTL and testbench

Sequential program loader that is the encoding end of the 16-bit instruction format: it takes decoded instruction fields through a valid/ready stream and packs them into 16-bit instruction words. Each packed word is written into instruction memory at consecutive addresses starting from a programmable base. It sits between a host/debug front end (UART command parser or testbench) and the instruction RAM that the fetch/decode path reads. A word it writes, decoded by the instruction decoder, returns the original fields.

---
 rtl/instr_encoder_loader_pkg.sv | 28 ++
 rtl/instr_field_packer.sv | 28 ++
 rtl/instr_encoder_loader.sv | 127 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Shared constants for the 16-bit instruction format and the loader FSM.
// The decoder uses the same field positions, so a word built here decodes back to its fields.
package instr_encoder_loader_pkg;

    // Field widths
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned INSTR_W = 16;

    // Field bit positions
    localparam int unsigned OPC_HI = 15;
    localparam int unsigned RD_LO  = 10;
    localparam int unsigned R1_LO  = 8;
    localparam int unsigned R2_LO  = 6;

    // Format select
    localparam logic FMT_R = 1'b0;
    localparam logic FMT_I = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone,
        StErr
    } load_state_e;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: format plus decoded fields -> 16-bit instruction word.
// Exact inverse of the instruction decoder.
module instr_field_packer
    import instr_encoder_loader_pkg::*;
(
    input  logic               fmt,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [REG_W-1:0]   rd,
    input  logic [REG_W-1:0]   r1,
    input  logic [REG_W-1:0]   r2,
    input  logic [IMM_W-1:0]   imm,
    output logic [INSTR_W-1:0] word
);

    // Place common fields, then either r2 (low six bits zero) or the immediate
    always_comb begin
        word                   = '0;
        word[OPC_HI -: OPC_W]  = opcode;
        word[RD_LO +: REG_W]   = rd;
        word[R1_LO +: REG_W]   = r1;
        if (fmt == FMT_I) begin
            word[IMM_W-1:0] = imm;
        end else begin
            word[R2_LO +: REG_W] = r2;
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts decoded field bundles, packs them into instruction words and
// writes them to instruction RAM at consecutive addresses from a programmable base.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_fmt,
    input  logic [OPC_W-1:0]    in_opcode,
    input  logic [REG_W-1:0]    in_rd,
    input  logic [REG_W-1:0]    in_r1,
    input  logic [REG_W-1:0]    in_r2,
    input  logic [IMM_W-1:0]    in_imm,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INSTR_W-1:0]  mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [INSTR_W-1:0]  checksum
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    load_state_e          state_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W:0]      count_q;
    logic [ADDR_W:0]      len_q;
    logic [INSTR_W-1:0]   word;
    logic                 accept;
    logic                 last_word;
    logic                 at_top;

    instr_field_packer u_packer (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .rd     (in_rd),
        .r1     (in_r1),
        .r2     (in_r2),
        .imm    (in_imm),
        .word   (word)
    );

    // Handshake and per-accept decode
    always_comb begin
        in_ready  = (state_q == StLoad) && !abort;
        accept    = in_valid && in_ready;
        last_word = (count_q + CNT_ONE) == len_q;
        at_top    = addr_q == LAST_ADDR;
        busy      = (state_q == StLoad) || (state_q == StDone);
    end

    // Load FSM with registered write port, done/error flags and running checksum
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            count_q   <= '0;
            len_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            checksum  <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state_q)
                StIdle, StErr: begin
                    if (start) begin
                        error    <= 1'b0;
                        checksum <= '0;
                        addr_q   <= base_addr;
                        count_q  <= '0;
                        len_q    <= length;
                        if (length == '0) begin
                            // Empty load completes immediately
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= word;
                        checksum  <= checksum ^ word;
                        addr_q    <= addr_q + ADDR_ONE;
                        count_q   <= count_q + CNT_ONE;
                        if (last_word) begin
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else if (at_top) begin
                            // Top of memory reached with words still owed: stop, never wrap
                            error   <= 1'b1;
                            state_q <= StErr;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader with a field-level reference model.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              abort;
    logic              in_valid;
    logic              in_ready;
    logic              in_fmt;
    logic [3:0]        in_opcode;
    logic [1:0]        in_rd;
    logic [1:0]        in_r1;
    logic [1:0]        in_r2;
    logic [7:0]        in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       checksum;

    instr_encoder_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_r1     (in_r1),
        .in_r2     (in_r2),
        .in_imm    (in_imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int fmt;
        int op;
        int rd;
        int r1;
        int r2;
        int imm;
    } bundle_t;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    bundle_t stim_q[$];
    wr_t     wr_q[$];
    int      n_tests  = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    int      done_cnt = 0;
    int      done_cyc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference encoding straight from the field positions
    function automatic int model_word(bundle_t b);
        return b.op * 4096 + b.rd * 1024 + b.r1 * 256 + ((b.fmt != 0) ? b.imm : b.r2 * 64);
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.fmt = int'($urandom_range(0, 1));
        b.op  = int'($urandom_range(0, 15));
        b.rd  = int'($urandom_range(0, 3));
        b.r1  = int'($urandom_range(0, 3));
        b.r2  = int'($urandom_range(0, 3));
        b.imm = int'($urandom_range(0, 255));
        return b;
    endfunction

    always @(posedge clk) cyc++;

    // Write/done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_q.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bundle_t b);
        in_fmt    = b.fmt[0];
        in_opcode = 4'(b.op);
        in_rd     = 2'(b.rd);
        in_r1     = 2'(b.r1);
        in_r2     = 2'(b.r2);
        in_imm    = 8'(b.imm);
    endtask

    // Offer one bundle for up to 4 cycles; acc reports whether it was taken
    task automatic send(input bundle_t b, output bit acc);
        drive(b);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 4 && !acc; k++) begin
            #1 acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input int b, input int len);
        base_addr = 8'(b);
        length    = 9'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic rand_stim(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(rand_bundle());
    endtask

    // Full load of stim_q checked against the model: writes, done, error, checksum
    task automatic run_load(input string tag, input int base, input int len);
        int n_exp;
        bit ovf;
        bit acc;
        int ck;
        ovf   = (base + len) > DEPTH;
        n_exp = ovf ? DEPTH - base : len;
        ck    = 0;
        wr_q.delete();
        done_cnt = 0;
        pulse_start(base, len);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_errclr"}, error, 0);
        check({tag, "_ckclr"}, checksum, 0);
        foreach (stim_q[i]) begin
            send(stim_q[i], acc);
            check($sformatf("%s_acc%0d", tag, i), acc, (i < n_exp));
        end
        tick();
        tick();
        check({tag, "_nwr"}, wr_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, base + i);
            check($sformatf("%s_data%0d", tag, i), wr_q[i].data, model_word(stim_q[i]));
        end
        for (int i = 0; i < n_exp; i++) ck = ck ^ model_word(stim_q[i]);
        check({tag, "_done"}, done_cnt, ovf ? 0 : 1);
        check({tag, "_error"}, error, ovf);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_cksum"}, checksum, ck);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bundle_t b;
        bit      acc;
        int      w;

        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        base_addr = '0; length = '0;
        in_fmt = 1'b0; in_opcode = '0; in_rd = '0; in_r1 = '0; in_r2 = '0; in_imm = '0;
        tick();
        tick();
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_cksum", checksum, 0);
        check("rst_ready", in_ready, 0);
        rst = 1'b0;
        tick();

        // Directed two-word load
        stim_q.delete();
        stim_q.push_back('{0, 3, 1, 2, 3, 0});
        stim_q.push_back('{1, 10, 2, 0, 0, 'h5F});
        run_load("t1", 'h10, 2);
        if (wr_q.size() >= 2) begin
            check("t1_w0", wr_q[0].data, 'h36C0);
            check("t1_w1", wr_q[1].data, 'hA85F);
            check("t1_b2b", wr_q[1].cyc - wr_q[0].cyc, 1);
            check("t1_done_cyc", done_cyc, wr_q[1].cyc);
        end
        check("t1_cksum_const", checksum, 'h9E9F);

        // Random round trip, decoded back to fields
        rand_stim(200);
        run_load("rt", 0, 200);
        for (int i = 0; i < wr_q.size() && i < 200; i++) begin
            w = wr_q[i].data;
            check($sformatf("rt_op%0d", i), w / 4096, stim_q[i].op);
            check($sformatf("rt_rd%0d", i), (w / 1024) % 4, stim_q[i].rd);
            check($sformatf("rt_r1%0d", i), (w / 256) % 4, stim_q[i].r1);
            if (stim_q[i].fmt != 0) begin
                check($sformatf("rt_imm%0d", i), w % 256, stim_q[i].imm);
            end else begin
                check($sformatf("rt_r2%0d", i), (w / 64) % 4, stim_q[i].r2);
                check($sformatf("rt_lo%0d", i), w % 64, 0);
            end
        end

        // Overflow at top of memory
        rand_stim(4);
        run_load("ovf", DEPTH - 2, 4);

        // Abort after one accept, with a same-cycle valid bundle
        wr_q.delete();
        done_cnt = 0;
        pulse_start('h20, 3);
        check("ab_errclr", error, 0);
        send(rand_bundle(), acc);
        check("ab_acc0", acc, 1);
        drive(rand_bundle());
        in_valid = 1'b1;
        abort    = 1'b1;
        #1 check("ab_ready", in_ready, 0);
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check("ab_nwr", wr_q.size(), 1);
        check("ab_done", done_cnt, 0);
        check("ab_error", error, 0);
        check("ab_busy", busy, 0);
        rand_stim(2);
        run_load("post_ab", 'h30, 2);

        // Zero-length start
        wr_q.delete();
        done_cnt = 0;
        pulse_start('h55, 0);
        check("z_done", done, 1);
        check("z_busy", busy, 0);
        tick();
        check("z_done_off", done, 0);
        check("z_done_cnt", done_cnt, 1);
        check("z_nwr", wr_q.size(), 0);

        // Start pulse during a load is ignored
        rand_stim(3);
        wr_q.delete();
        done_cnt = 0;
        pulse_start('h40, 3);
        send(stim_q[0], acc);
        pulse_start('h80, 1);
        send(stim_q[1], acc);
        send(stim_q[2], acc);
        tick();
        tick();
        check("sl_nwr", wr_q.size(), 3);
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            check($sformatf("sl_addr%0d", i), wr_q[i].addr, 'h40 + i);
            check($sformatf("sl_data%0d", i), wr_q[i].data, model_word(stim_q[i]));
        end
        check("sl_done", done_cnt, 1);

        // Reset in the middle of a load with valid high
        pulse_start('h10, 5);
        send(rand_bundle(), acc);
        check("mr_acc", acc, 1);
        drive(rand_bundle());
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        check("mr_we", mem_we, 0);
        check("mr_busy", busy, 0);
        check("mr_cksum", checksum, 0);
        check("mr_ready", in_ready, 0);
        check("mr_done", done, 0);
        check("mr_addr", mem_addr, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
